// File: rtl/hc_sr04_pkg.sv
// Shared definitions for the HC-SR04 emulator and controller cores.
// Holds the FSM state encoding, the slot register map and the bit positions
// of the ctrl and status registers. It has no ports.
package hc_sr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG_HI,
        ST_DELAY,
        ST_ECHO,
        ST_HOLDOFF
    } emu_state_t;

    // Slot register map; only addr[1:0] is decoded
    localparam logic [1:0] REG_WIDTH  = 2'd0;
    localparam logic [1:0] REG_DELAY  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // ctrl register bits
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_DROP_BIT   = 1;

    // status register fields
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_ECHO_BIT  = 1;
    localparam int STAT_SHORT_LSB = 8;
    localparam int STAT_PULSE_LSB = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset, clears both flops
//   d       - asynchronous input
//   q       - synchronized output, two clk cycles behind d
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hc_sr04_emu_core.sv
// HC-SR04 sensor emulator on the MMIO slot bus. Validates the width of the
// trigger pulse, waits delay_reg ticks after the trigger falls, then drives
// echo high for width_reg ticks. A holdoff period follows each measurement.
// Ports:
//   clk, reset_n            - system clock, asynchronous active-low reset
//   cs, read, write, addr   - slot bus control (addr[1:0] decoded)
//   wr_data / rd_data       - slot write data / combinational read data
//   trigger                 - asynchronous trigger from the controller
//   echo                    - registered emulated echo
module hc_sr04_emu_core
    import hc_sr04_pkg::*;
#(
    parameter int unsigned MIN_TRIG_TICKS = 1000,
    parameter int unsigned HOLDOFF_TICKS  = 6000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        trigger,
    output logic        echo
);

    localparam logic [31:0] MIN_TRIG  = 32'(MIN_TRIG_TICKS);
    localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_TICKS - 1);

    logic [31:0] width_reg, delay_reg;
    logic        enable, drop;
    logic [31:0] width_sh, delay_sh;
    logic        drop_sh;
    logic [7:0]  short_cnt;
    logic [15:0] pulse_cnt;
    emu_state_t  state, state_next;
    logic [31:0] cnt, cnt_next;
    logic        latch_shadow, short_inc, pulse_inc;
    logic        trig_s;
    logic        reg_wr;
    logic        unused_bus;

    // Reads have no side effects, so the read strobe and upper address bits are not needed
    assign unused_bus = &{1'b0, read, addr[4:2]};
    assign reg_wr     = cs && write;

    sync_2ff u_trig_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (trigger),
        .q       (trig_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            echo  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            // Registered from the next state so echo is high exactly while state is ST_ECHO
            echo  <= (state_next == ST_ECHO);
        end
    end

    // Next-state logic; clearing enable forces idle from any state
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        latch_shadow = 1'b0;
        short_inc    = 1'b0;
        pulse_inc    = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig_s) begin
                        state_next = ST_TRIG_HI;
                        cnt_next   = 32'd1;
                    end
                end
                ST_TRIG_HI: begin
                    if (trig_s) begin
                        if (cnt != '1) cnt_next = cnt + 32'd1;
                    end else if (cnt >= MIN_TRIG) begin
                        state_next   = ST_DELAY;
                        cnt_next     = '0;
                        latch_shadow = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                        short_inc  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (cnt == delay_sh) begin
                        if (drop_sh || (width_sh == '0)) begin
                            state_next = ST_HOLDOFF;
                            cnt_next   = '0;
                        end else begin
                            state_next = ST_ECHO;
                            cnt_next   = 32'd1;
                            pulse_inc  = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + 32'd1;
                    end
                end
                ST_ECHO: begin
                    if (cnt == width_sh) begin
                        state_next = ST_HOLDOFF;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 32'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 32'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Writable registers and the shadows that freeze a measurement's parameters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_reg <= '0;
            delay_reg <= '0;
            enable    <= 1'b0;
            drop      <= 1'b0;
            width_sh  <= '0;
            delay_sh  <= '0;
            drop_sh   <= 1'b0;
        end else begin
            if (reg_wr && (addr[1:0] == REG_WIDTH)) width_reg <= wr_data;
            if (reg_wr && (addr[1:0] == REG_DELAY)) delay_reg <= wr_data;
            if (reg_wr && (addr[1:0] == REG_CTRL)) begin
                enable <= wr_data[CTRL_ENABLE_BIT];
                drop   <= wr_data[CTRL_DROP_BIT];
            end
            if (latch_shadow) begin
                width_sh <= width_reg;
                delay_sh <= delay_reg;
                drop_sh  <= drop;
            end
        end
    end

    // Event counters; a status write clears both and beats a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            short_cnt <= '0;
            pulse_cnt <= '0;
        end else if (reg_wr && (addr[1:0] == REG_STATUS)) begin
            short_cnt <= '0;
            pulse_cnt <= '0;
        end else begin
            if (short_inc && (short_cnt != 8'hFF)) short_cnt <= short_cnt + 8'd1;
            if (pulse_inc) pulse_cnt <= pulse_cnt + 16'd1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr[1:0])
            REG_WIDTH:  rd_data = width_reg;
            REG_DELAY:  rd_data = delay_reg;
            REG_CTRL: begin
                rd_data[CTRL_ENABLE_BIT] = enable;
                rd_data[CTRL_DROP_BIT]   = drop;
            end
            REG_STATUS: begin
                rd_data[STAT_BUSY_BIT]          = (state != ST_IDLE);
                rd_data[STAT_ECHO_BIT]          = echo;
                rd_data[STAT_SHORT_LSB +: 8]    = short_cnt;
                rd_data[STAT_PULSE_LSB +: 16]   = pulse_cnt;
            end
        endcase
    end

endmodule
